// File: rtl/pcie_rx.sv
// pcie_rx: receive end of the DATA/VALID byte link. Demultiplexes tagged bytes
// into four class FIFOs, drives flow-control flags back to the transmitter, and
// offers pop-driven per-channel readout with sticky overflow reporting.
module pcie_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = 3
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     DATA_IN,
  input  logic                      VALID_IN,
  input  logic [3:0]                POP,
  output logic [4*DATA_WIDTH-1:0]   DATA_OUT,
  output logic [3:0]                EMPTY,
  output logic [3:0]                ALMOST_FULL,
  output logic                      PAUSE,
  output logic                      ERR,
  output logic [7:0]                DROP_CNT,
  output logic [1:0]                STATE
);

  localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AfCount   = (ADDR_WIDTH+1)'(AF_THRESH);

  typedef enum logic [1:0] {
    StInit   = 2'd0,
    StIdle   = 2'd1,
    StActive = 2'd2,
    StError  = 2'd3
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem  [4][FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr [4];
  logic [ADDR_WIDTH-1:0] r_rptr [4];
  logic [ADDR_WIDTH:0]   r_count[4];
  logic [DATA_WIDTH-1:0] r_dout [4];
  logic                  r_pause;
  logic                  r_err;
  logic [7:0]            r_drop_cnt;

  logic [1:0] w_chan;
  logic       w_run;
  logic [3:0] w_full;
  logic [3:0] w_pop;
  logic [3:0] w_push;
  logic       w_ovf;
  logic       w_drop;
  logic [3:0] w_empty;
  logic [3:0] w_af;

  // Decode push/pop qualifiers and flags from the registered counts.
  always_comb begin
    w_chan = DATA_IN[DATA_WIDTH-1 -: 2];
    w_run  = (r_state == StIdle) || (r_state == StActive);
    w_full  = '0;
    w_pop   = '0;
    w_push  = '0;
    w_empty = '0;
    w_af    = '0;
    for (int i = 0; i < 4; i++) begin
      w_empty[i] = (r_count[i] == '0);
      w_af[i]    = (r_count[i] >= AfCount);
      w_full[i]  = (r_count[i] == FullCount);
      w_pop[i]   = POP[i] && !w_empty[i] && (r_state != StInit);
      // A pop on a full channel frees the slot for a same-cycle push.
      w_push[i]  = w_run && VALID_IN && (w_chan == 2'(i)) && (!w_full[i] || w_pop[i]);
    end
    w_ovf  = w_run && VALID_IN && w_full[w_chan] && !w_pop[w_chan];
    w_drop = VALID_IN && (w_ovf || (r_state == StError));
  end

  // Next-state logic; ERROR is only left through reset.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StInit:   w_state_nxt = StIdle;
      StIdle: begin
        if (w_ovf)         w_state_nxt = StError;
        else if (VALID_IN) w_state_nxt = StActive;
      end
      StActive: begin
        if (w_ovf)                       w_state_nxt = StError;
        else if (&w_empty && !VALID_IN)  w_state_nxt = StIdle;
      end
      StError:  w_state_nxt = StError;
      default:  w_state_nxt = StInit;
    endcase
  end

  // State register and sticky error/drop bookkeeping.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state    <= StInit;
      r_pause    <= 1'b0;
      r_err      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pause <= |w_af;
      if (w_ovf) r_err <= 1'b1;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Per-channel pointers, occupancy counts and registered read data.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
        r_dout[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + ADDR_WIDTH'(1);
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + ADDR_WIDTH'(1);
          r_dout[i] <= r_mem[i][r_rptr[i]];
        end
        unique case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + (ADDR_WIDTH+1)'(1);
          2'b01:   r_count[i] <= r_count[i] - (ADDR_WIDTH+1)'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // Storage array; contents are unreachable after reset since counts clear.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= DATA_IN;
    end
  end

  // Pack per-channel read data and drive the status outputs.
  always_comb begin
    DATA_OUT = '0;
    for (int i = 0; i < 4; i++) begin
      DATA_OUT[i*DATA_WIDTH +: DATA_WIDTH] = r_dout[i];
    end
    EMPTY       = w_empty;
    ALMOST_FULL = w_af;
    PAUSE       = r_pause;
    ERR         = r_err;
    DROP_CNT    = r_drop_cnt;
    STATE       = r_state;
  end

endmodule

// File: tb/tb_pcie_rx.sv
// tb_pcie_rx: directed vector table for the basic push/pop/flag behaviour, plus
// hand-written sequences for full-channel push+pop, overflow and async reset.
module tb_pcie_rx;

  logic        CLK = 1'b0;
  logic        reset;
  logic [7:0]  DATA_IN;
  logic        VALID_IN;
  logic [3:0]  POP;
  logic [31:0] DATA_OUT;
  logic [3:0]  EMPTY;
  logic [3:0]  ALMOST_FULL;
  logic        PAUSE;
  logic        ERR;
  logic [7:0]  DROP_CNT;
  logic [1:0]  STATE;

  int n_checks = 0;
  int n_errors = 0;

  pcie_rx #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4),
    .ADDR_WIDTH(2),
    .AF_THRESH (3)
  ) u_dut (
    .CLK        (CLK),
    .reset      (reset),
    .DATA_IN    (DATA_IN),
    .VALID_IN   (VALID_IN),
    .POP        (POP),
    .DATA_OUT   (DATA_OUT),
    .EMPTY      (EMPTY),
    .ALMOST_FULL(ALMOST_FULL),
    .PAUSE      (PAUSE),
    .ERR        (ERR),
    .DROP_CNT   (DROP_CNT),
    .STATE      (STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        valid;
    logic [7:0]  data;
    logic [3:0]  pop;
    logic [31:0] dout;
    logic [3:0]  empty;
    logic [3:0]  af;
    logic        pause;
    logic        err;
    logic [7:0]  drop;
    logic [1:0]  state;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic [3:0] p);
    @(negedge CLK);
    VALID_IN = v;
    DATA_IN  = d;
    POP      = p;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".dout"},  DATA_OUT,           32'h0);
    chk({tag, ".empty"}, {28'h0, EMPTY},     32'hF);
    chk({tag, ".af"},    {28'h0, ALMOST_FULL}, 32'h0);
    chk({tag, ".pause"}, {31'h0, PAUSE},     32'h0);
    chk({tag, ".err"},   {31'h0, ERR},       32'h0);
    chk({tag, ".drop"},  {24'h0, DROP_CNT},  32'h0);
    chk({tag, ".state"}, {30'h0, STATE},     32'h0);
  endtask

  initial begin
    //            v  data   pop   dout          empty af    p  e  drop  st
    vecs[0]  = '{1'b0, 8'h00, 4'h0, 32'h00000000, 4'hF, 4'h0, 0, 0, 8'd0, 2'd1};
    vecs[1]  = '{1'b0, 8'h00, 4'h0, 32'h00000000, 4'hF, 4'h0, 0, 0, 8'd0, 2'd1};
    vecs[2]  = '{1'b1, 8'h05, 4'h0, 32'h00000000, 4'hE, 4'h0, 0, 0, 8'd0, 2'd2};
    vecs[3]  = '{1'b1, 8'h47, 4'h0, 32'h00000000, 4'hC, 4'h0, 0, 0, 8'd0, 2'd2};
    vecs[4]  = '{1'b1, 8'h8A, 4'h0, 32'h00000000, 4'h8, 4'h0, 0, 0, 8'd0, 2'd2};
    vecs[5]  = '{1'b1, 8'hC3, 4'h0, 32'h00000000, 4'h0, 4'h0, 0, 0, 8'd0, 2'd2};
    vecs[6]  = '{1'b0, 8'h00, 4'hF, 32'hC38A4705, 4'hF, 4'h0, 0, 0, 8'd0, 2'd2};
    vecs[7]  = '{1'b0, 8'h00, 4'h0, 32'hC38A4705, 4'hF, 4'h0, 0, 0, 8'd0, 2'd1};
    vecs[8]  = '{1'b1, 8'h01, 4'h0, 32'hC38A4705, 4'hE, 4'h0, 0, 0, 8'd0, 2'd2};
    vecs[9]  = '{1'b1, 8'h02, 4'h0, 32'hC38A4705, 4'hE, 4'h0, 0, 0, 8'd0, 2'd2};
    vecs[10] = '{1'b1, 8'h03, 4'h0, 32'hC38A4705, 4'hE, 4'h1, 0, 0, 8'd0, 2'd2};
    vecs[11] = '{1'b0, 8'h00, 4'h0, 32'hC38A4705, 4'hE, 4'h1, 1, 0, 8'd0, 2'd2};
    vecs[12] = '{1'b0, 8'h00, 4'h1, 32'hC38A4701, 4'hE, 4'h0, 1, 0, 8'd0, 2'd2};
    vecs[13] = '{1'b0, 8'h00, 4'h0, 32'hC38A4701, 4'hE, 4'h0, 0, 0, 8'd0, 2'd2};
    vecs[14] = '{1'b0, 8'h00, 4'h1, 32'hC38A4702, 4'hE, 4'h0, 0, 0, 8'd0, 2'd2};
    vecs[15] = '{1'b0, 8'h00, 4'h1, 32'hC38A4703, 4'hF, 4'h0, 0, 0, 8'd0, 2'd2};
    vecs[16] = '{1'b0, 8'h00, 4'h0, 32'hC38A4703, 4'hF, 4'h0, 0, 0, 8'd0, 2'd1};

    reset    = 1'b1;
    VALID_IN = 1'b0;
    DATA_IN  = 8'h00;
    POP      = 4'h0;
    #12;
    chk_reset_vals("reset");
    @(negedge CLK);
    reset = 1'b0;

    // Basic demux, readout, flag and PAUSE timing.
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].valid, vecs[i].data, vecs[i].pop);
      chk($sformatf("vec%0d.dout", i),  DATA_OUT,               vecs[i].dout);
      chk($sformatf("vec%0d.empty", i), {28'h0, EMPTY},         {28'h0, vecs[i].empty});
      chk($sformatf("vec%0d.af", i),    {28'h0, ALMOST_FULL},   {28'h0, vecs[i].af});
      chk($sformatf("vec%0d.pause", i), {31'h0, PAUSE},         {31'h0, vecs[i].pause});
      chk($sformatf("vec%0d.err", i),   {31'h0, ERR},           {31'h0, vecs[i].err});
      chk($sformatf("vec%0d.drop", i),  {24'h0, DROP_CNT},      {24'h0, vecs[i].drop});
      chk($sformatf("vec%0d.state", i), {30'h0, STATE},         {30'h0, vecs[i].state});
    end

    // Full channel 1 with simultaneous push and pop: no overflow.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h41 + 8'(i), 4'h0);
    chk("ch1_full.af",    {28'h0, ALMOST_FULL}, 32'h2);
    chk("ch1_full.empty", {28'h0, EMPTY},       32'hD);
    step(1'b1, 8'h45, 4'h2);
    chk("ch1_pp.dout",  {24'h0, DATA_OUT[15:8]}, 32'h41);
    chk("ch1_pp.err",   {31'h0, ERR},            32'h0);
    chk("ch1_pp.state", {30'h0, STATE},          32'h2);
    chk("ch1_pp.af",    {28'h0, ALMOST_FULL},    32'h2);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 4'h2);
      chk($sformatf("ch1_pop%0d", i), {24'h0, DATA_OUT[15:8]}, 32'h42 + i);
    end
    chk("ch1_drain.empty", {28'h0, EMPTY}, 32'hF);
    chk("ch1_drain.drop",  {24'h0, DROP_CNT}, 32'h0);
    step(1'b0, 8'h00, 4'h0);
    chk("ch1_idle.state", {30'h0, STATE}, 32'h1);

    // Overflow on channel 2; ERROR drops every later byte but pops continue.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h81 + 8'(i), 4'h0);
    step(1'b1, 8'h99, 4'h0);
    chk("ovf.err",   {31'h0, ERR},       32'h1);
    chk("ovf.drop",  {24'h0, DROP_CNT},  32'h1);
    chk("ovf.state", {30'h0, STATE},     32'h3);
    chk("ovf.empty", {28'h0, EMPTY},     32'hB);
    step(1'b1, 8'h9A, 4'h0);
    step(1'b1, 8'h9B, 4'h0);
    step(1'b1, 8'h05, 4'h0);
    chk("err_drop.drop",  {24'h0, DROP_CNT}, 32'h4);
    chk("err_drop.empty", {28'h0, EMPTY},    32'hB);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 4'h4);
      chk($sformatf("ch2_pop%0d", i), {24'h0, DATA_OUT[23:16]}, 32'h81 + i);
    end
    chk("ch2_drain.empty", {28'h0, EMPTY},    32'hF);
    chk("ch2_drain.state", {30'h0, STATE},    32'h3);
    chk("ch2_drain.drop",  {24'h0, DROP_CNT}, 32'h4);

    // Asynchronous reset between edges clears ERROR state immediately.
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("arst_err");
    @(negedge CLK);
    reset = 1'b0;
    step(1'b0, 8'h00, 4'h0);
    chk("post_rst.state", {30'h0, STATE}, 32'h1);
    step(1'b1, 8'h05, 4'h0);
    step(1'b1, 8'h47, 4'h0);
    step(1'b1, 8'h8A, 4'h0);
    step(1'b0, 8'h00, 4'h1);
    chk("mid.dout",  DATA_OUT,       32'h00000005);
    chk("mid.empty", {28'h0, EMPTY}, 32'h9);
    step(1'b1, 8'hC3, 4'h0);
    chk("mid2.empty", {28'h0, EMPTY}, 32'h1);

    // Reset mid-stream with data buffered: contents discarded.
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("arst_data");
    @(negedge CLK);
    reset = 1'b0;
    step(1'b0, 8'h00, 4'hF);
    chk("pop_init.dout",  DATA_OUT,       32'h0);
    chk("pop_init.empty", {28'h0, EMPTY}, 32'hF);
    chk("pop_init.state", {30'h0, STATE}, 32'h1);
    step(1'b0, 8'h00, 4'hF);
    chk("pop_empty.dout",  DATA_OUT,       32'h0);
    chk("pop_empty.empty", {28'h0, EMPTY}, 32'hF);
    chk("pop_empty.err",   {31'h0, ERR},   32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
